// File: rtl/csla_seq_addsub.sv
// Iterative carry-select add/subtract: one dual-rail chunk adder reused over
// WIDTH in an LSB_W-bit chunk followed by BLK-bit chunks, with valid/ready on both sides.
module csla_seq_addsub #(
    parameter int WIDTH = 66,
    parameter int BLK   = 8,
    parameter int LSB_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cflag,
    output logic             zflag,
    output logic [1:0]       dbg_state
);

    localparam int LAST_K = (WIDTH - LSB_W) / BLK;
    localparam int CNT_W  = $clog2(LAST_K + 1);

    localparam logic [WIDTH-1:0] BLK_MASK   = {{(WIDTH-BLK){1'b0}}, {BLK{1'b1}}};
    localparam logic [WIDTH-1:0] LSB_MASK   = {{(WIDTH-LSB_W){1'b0}}, {LSB_W{1'b1}}};
    localparam logic [BLK-1:0]   LSB_MASK_B = {{(BLK-LSB_W){1'b0}}, {LSB_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE, out_valid only in DONE, so an accept
    // and a result handoff can never share an edge.

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cflag_q, cflag_d;
    logic             zflag_q, zflag_d;

    int               off;
    logic [WIDTH-1:0] a_sh, b_sh, mask;
    logic [BLK-1:0]   ca, cb;
    logic [BLK:0]     sum0, sum1, sel;
    logic             cout;
    logic [WIDTH-1:0] res_merged;

    // Chunk datapath: both carry-in candidates computed, carry register selects.
    always_comb begin
        off  = (cnt_q == '0) ? 0 : LSB_W + BLK * (int'(cnt_q) - 1);
        mask = (cnt_q == '0) ? LSB_MASK : BLK_MASK;
        a_sh = a_q >> off;
        b_sh = b_q >> off;
        ca   = a_sh[BLK-1:0];
        cb   = b_sh[BLK-1:0];
        if (cnt_q == '0) begin
            ca = ca & LSB_MASK_B;
            cb = cb & LSB_MASK_B;
        end
        sum0 = {1'b0, ca} + {1'b0, cb};
        sum1 = sum0 + {{BLK{1'b0}}, 1'b1};
        sel  = carry_q ? sum1 : sum0;
        // The narrow first chunk carries out of bit LSB_W, not bit BLK.
        cout = (cnt_q == '0) ? sel[LSB_W] : sel[BLK];
        res_merged = (res_q & ~(mask << off))
                   | (({{(WIDTH-BLK){1'b0}}, sel[BLK-1:0]} & mask) << off);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cflag_d = cflag_q;
        zflag_d = zflag_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    op_d    = op;
                    carry_d = op;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = res_merged;
                carry_d = cout;
                if (cnt_q == CNT_W'(LAST_K)) begin
                    // Subtract reports borrow, the inverse of the final carry.
                    cflag_d = cout ^ op_q;
                    zflag_d = (res_merged == '0);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cflag_q <= 1'b0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cflag_q <= cflag_d;
            zflag_q <= zflag_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
    assign cflag     = cflag_q;
    assign zflag     = zflag_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_csla_seq_addsub.sv
// Directed bench for csla_seq_addsub: latency, carry/borrow boundaries,
// backpressure hold and asynchronous reset mid-operation.
module tb_csla_seq_addsub;

    localparam int W = 66;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         cflag;
    logic         zflag;
    logic [1:0]   dbg_state;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [W+1:0] exp_q[$];

    csla_seq_addsub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cflag     (cflag),
        .zflag     (zflag),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: one full operation, optional backpressure for hold cycles.
    task automatic do_op(input logic o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] e_res, input logic e_c, input logic e_z,
                         input int hold);
        logic [W+1:0] e;
        int           cycles;
        exp_q.push_back({e_res, e_c, e_z});
        @(negedge clk);
        check("in_ready_idle", {65'd0, in_ready}, 1);
        in_valid  = 1'b1;
        op        = o;
        a         = va;
        b         = vb;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_busy", {65'd0, in_ready}, 0);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (!out_valid && in_ready) check("in_ready_run", 1, 0);
        end
        check("latency", W'(cycles), 9);
        e = exp_q.pop_front();
        check("res",   res,                 e[W+1:2]);
        check("cflag", {65'd0, cflag},      {65'd0, e[1]});
        check("zflag", {65'd0, zflag},      {65'd0, e[0]});
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            a        = ~a;
            b        = b + 1'b1;
            op       = ~op;
            @(posedge clk);
            @(negedge clk);
            check("hold_res",   res, e[W+1:2]);
            check("hold_flags", {64'd0, cflag, zflag}, {64'd0, e[1:0]});
            check("hold_valid", {64'd0, out_valid, in_ready}, {64'd0, 2'b10});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_valid", {65'd0, out_valid}, 0);
        check("handoff_idle",  {64'd0, dbg_state}, 0);
        check("handoff_ready", {65'd0, in_ready}, 1);
    endtask

    initial begin
        bit seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #3;
        check("rst_outs", {62'd0, out_valid, cflag, zflag, |res}, 0);
        check("rst_state", {64'd0, dbg_state}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b1, 66'd5, 66'd3, 66'd2, 1'b0, 1'b0, 0);
        do_op(1'b1, 66'd3, 66'd5, 66'h3_FFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 0);
        do_op(1'b0, 66'h3_FFFF_FFFF_FFFF_FFFF, 66'd1, 66'd0, 1'b1, 1'b1, 0);
        do_op(1'b0, 66'h3FF, 66'd1, 66'h400, 1'b0, 1'b0, 0);
        do_op(1'b1, 66'h400, 66'd1, 66'h3FF, 1'b0, 1'b0, 0);
        do_op(1'b0, 66'h1_0000_0000_0000_0000, 66'h2_0000_0000_0000_0001,
              66'h3_0000_0000_0000_0001, 1'b0, 1'b0, 0);
        do_op(1'b1, 66'h2_AAAA_5555_0000_1234, 66'h2_AAAA_5555_0000_1234,
              66'd0, 1'b0, 1'b1, 6);

        // No second accept after the handoff with in_valid low.
        @(negedge clk);
        check("idle_stays", {64'd0, dbg_state}, 0);

        // Asynchronous reset while chunk 4 is pending.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 1'b0;
        a        = 66'h3_FFFF_FFFF_FFFF_FFFF;
        b        = 66'h0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_run", {64'd0, dbg_state}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_res",   res, 0);
        check("arst_flags", {63'd0, out_valid, cflag, zflag}, 0);
        check("arst_state", {64'd0, dbg_state}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", {65'd0, in_ready}, 1);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("arst_no_result", {65'd0, seen_valid}, 0);

        do_op(1'b0, 66'd7, 66'd9, 66'd16, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
